// File: rtl/cpu_mem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_mem_loader
//  Description : Host-side initiator for the CPU external memory ports.
//                Streams a program into instruction memory, runs the CPU for
//                a latched number of cycles, then streams data memory back
//                out over a valid/ready interface.
//  Revision    : 1.0  initial release
// ============================================================================
module cpu_mem_loader #(
    parameter int IMEM_WORDS = 512,
    parameter int DMEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        arst,
    input  logic        start,
    input  logic [31:0] run_cycles,
    input  logic [10:0] dump_words,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_data,
    input  logic        s_last,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [63:0] m_data,
    output logic        m_last,
    output logic        cpu_enable,
    output logic [63:0] addr_ext,
    output logic        wen_ext,
    output logic        ren_ext,
    output logic [31:0] wdata_ext,
    output logic [63:0] addr_ext_2,
    output logic        wen_ext_2,
    output logic        ren_ext_2,
    output logic [63:0] wdata_ext_2,
    input  logic [63:0] rdata_ext_2,
    output logic        busy,
    output logic        done,
    output logic        error
);

    // Program word counter saturates at IMEM_WORDS, so it needs one extra bit.
    localparam int                c_IW   = $clog2(IMEM_WORDS) + 1;
    localparam logic [c_IW-1:0]   c_IMEM = c_IW'(IMEM_WORDS);
    localparam logic [10:0]       c_DMEM = 11'(DMEM_WORDS);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_RUN       = 3'd2,
        S_DUMP_RD   = 3'd3,   // ren_ext_2 visible this cycle
        S_DUMP_CAP  = 3'd4,   // rdata_ext_2 valid, captured at end of cycle
        S_DUMP_HOLD = 3'd5,   // m_valid held until m_ready
        S_DONE      = 3'd6
    } state_t;

    state_t          state_q,      state_d;
    logic [c_IW-1:0] load_idx_q,   load_idx_d;
    logic [31:0]     run_cnt_q,    run_cnt_d;
    logic [10:0]     dump_len_q,   dump_len_d;
    logic [10:0]     dump_idx_q,   dump_idx_d;
    logic            s_ready_q,    s_ready_d;
    logic            m_valid_q,    m_valid_d;
    logic [63:0]     m_data_q,     m_data_d;
    logic            m_last_q,     m_last_d;
    logic            cpu_enable_q, cpu_enable_d;
    logic [63:0]     addr_ext_q,   addr_ext_d;
    logic            wen_ext_q,    wen_ext_d;
    logic [31:0]     wdata_ext_q,  wdata_ext_d;
    logic [63:0]     addr_ext_2_q, addr_ext_2_d;
    logic            ren_ext_2_q,  ren_ext_2_d;
    logic            busy_q,       busy_d;
    logic            done_q,       done_d;
    logic            error_q,      error_d;

    logic [10:0]     dump_idx_next;
    assign dump_idx_next = dump_idx_q + 11'd1;

    // Next-state and next-output computation; strobes default low every cycle.
    always_comb begin
        state_d      = state_q;
        load_idx_d   = load_idx_q;
        run_cnt_d    = run_cnt_q;
        dump_len_d   = dump_len_q;
        dump_idx_d   = dump_idx_q;
        m_valid_d    = m_valid_q;
        m_data_d     = m_data_q;
        m_last_d     = m_last_q;
        cpu_enable_d = 1'b0;
        addr_ext_d   = addr_ext_q;
        wen_ext_d    = 1'b0;
        wdata_ext_d  = wdata_ext_q;
        addr_ext_2_d = addr_ext_2_q;
        ren_ext_2_d  = 1'b0;
        error_d      = error_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d    = S_LOAD;
                    run_cnt_d  = run_cycles;
                    dump_len_d = (dump_words > c_DMEM) ? c_DMEM : dump_words;
                    load_idx_d = '0;
                    dump_idx_d = '0;
                    m_last_d   = 1'b0;
                    error_d    = 1'b0;
                end
            end
            S_LOAD: begin
                if (s_valid && s_ready_q) begin
                    if (load_idx_q < c_IMEM) begin
                        wen_ext_d   = 1'b1;
                        addr_ext_d  = 64'(load_idx_q) << 2;
                        wdata_ext_d = s_data;
                        load_idx_d  = load_idx_q + c_IW'(1);
                    end else begin
                        // Overflow words are swallowed so the host stream never stalls.
                        error_d = 1'b1;
                    end
                    if (s_last) begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                // The final write strobe is visible during the first RUN cycle;
                // cpu_enable only rises on the cycle after it.
                if (run_cnt_q != 32'd0) begin
                    cpu_enable_d = 1'b1;
                    run_cnt_d    = run_cnt_q - 32'd1;
                end else if (dump_len_q == 11'd0) begin
                    state_d = S_DONE;
                end else begin
                    state_d      = S_DUMP_RD;
                    ren_ext_2_d  = 1'b1;
                    addr_ext_2_d = 64'd0;
                    dump_idx_d   = 11'd0;
                end
            end
            S_DUMP_RD: begin
                state_d = S_DUMP_CAP;
            end
            S_DUMP_CAP: begin
                m_data_d  = rdata_ext_2;
                m_valid_d = 1'b1;
                m_last_d  = (dump_idx_q == dump_len_q - 11'd1);
                state_d   = S_DUMP_HOLD;
            end
            S_DUMP_HOLD: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    if (m_last_q) begin
                        m_last_d = 1'b0;
                        state_d  = S_DONE;
                    end else begin
                        dump_idx_d   = dump_idx_next;
                        ren_ext_2_d  = 1'b1;
                        addr_ext_2_d = 64'(dump_idx_next) << 3;
                        state_d      = S_DUMP_RD;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        s_ready_d = (state_d == S_LOAD);
        busy_d    = !((state_d == S_IDLE) || (state_d == S_DONE));
        done_d    = (state_d == S_DONE);
    end

    // State and registered outputs; reset clears everything immediately.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q      <= S_IDLE;
            load_idx_q   <= '0;
            run_cnt_q    <= '0;
            dump_len_q   <= '0;
            dump_idx_q   <= '0;
            s_ready_q    <= 1'b0;
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            m_last_q     <= 1'b0;
            cpu_enable_q <= 1'b0;
            addr_ext_q   <= '0;
            wen_ext_q    <= 1'b0;
            wdata_ext_q  <= '0;
            addr_ext_2_q <= '0;
            ren_ext_2_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            load_idx_q   <= load_idx_d;
            run_cnt_q    <= run_cnt_d;
            dump_len_q   <= dump_len_d;
            dump_idx_q   <= dump_idx_d;
            s_ready_q    <= s_ready_d;
            m_valid_q    <= m_valid_d;
            m_data_q     <= m_data_d;
            m_last_q     <= m_last_d;
            cpu_enable_q <= cpu_enable_d;
            addr_ext_q   <= addr_ext_d;
            wen_ext_q    <= wen_ext_d;
            wdata_ext_q  <= wdata_ext_d;
            addr_ext_2_q <= addr_ext_2_d;
            ren_ext_2_q  <= ren_ext_2_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign s_ready     = s_ready_q;
    assign m_valid     = m_valid_q;
    assign m_data      = m_data_q;
    assign m_last      = m_last_q;
    assign cpu_enable  = cpu_enable_q;
    assign addr_ext    = addr_ext_q;
    assign wen_ext     = wen_ext_q;
    assign ren_ext     = 1'b0;
    assign wdata_ext   = wdata_ext_q;
    assign addr_ext_2  = addr_ext_2_q;
    assign wen_ext_2   = 1'b0;
    assign ren_ext_2   = ren_ext_2_q;
    assign wdata_ext_2 = 64'd0;
    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;

endmodule
`default_nettype wire
